// File: rtl/rv32i_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address and
// queues returned words with their PCs in a 2-entry prefetch buffer for decode.
module rv32i_fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic [WIDTH-1:0] i_imem_inst,
    output logic             o_if_valid,
    output logic [WIDTH-1:0] o_if_inst,
    output logic [WIDTH-1:0] o_if_pc,
    input  logic             i_id_ready,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_halt,
    output logic             o_halted,
    output logic             o_fault
);

    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FAULT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [1:0]       count;
    logic [WIDTH-1:0] buf_pc   [2];
    logic [WIDTH-1:0] buf_inst [2];
    logic             pop;
    logic             push;
    logic             take_redirect;
    logic             misaligned;

    // A fault locks the controller until reset, so redirects are only honoured outside FAULT.
    assign take_redirect = i_redirect && (state != FAULT);
    assign misaligned    = i_redirect_pc[1:0] != 2'b00;
    assign pop           = o_if_valid && i_id_ready;
    assign push          = (state == RUN) && !i_halt && !i_redirect && ((count != 2'd2) || pop);

    assign o_imem_addr = pc;
    assign o_if_valid  = count != 2'd0;
    assign o_if_inst   = o_if_valid ? buf_inst[0] : NOP;
    assign o_if_pc     = o_if_valid ? buf_pc[0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_halted   = 1'b0;
        o_fault    = 1'b0;
        if (take_redirect) begin
            state_next = misaligned ? FAULT : RUN;
        end else if ((state == RUN) && i_halt) begin
            state_next = HALT;
        end
        o_halted = (state == HALT) && (count == 2'd0);
        o_fault  = (state == FAULT);
    end

    // Entry 0 is always the head; a pop shifts entry 1 down so the FIFO stays in order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            count       <= 2'd0;
            buf_pc[0]   <= '0;
            buf_pc[1]   <= '0;
            buf_inst[0] <= '0;
            buf_inst[1] <= '0;
        end else if (take_redirect) begin
            pc    <= i_redirect_pc;
            count <= 2'd0;
        end else begin
            if (push) begin
                pc <= pc + WIDTH'(4);
            end
            case ({push, pop})
                2'b10: begin
                    buf_pc[count[0]]   <= pc;
                    buf_inst[count[0]] <= i_imem_inst;
                    count              <= count + 2'd1;
                end
                2'b01: begin
                    buf_pc[0]   <= buf_pc[1];
                    buf_inst[0] <= buf_inst[1];
                    count       <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        buf_pc[0]   <= buf_pc[1];
                        buf_inst[0] <= buf_inst[1];
                        buf_pc[1]   <= pc;
                        buf_inst[1] <= i_imem_inst;
                    end else begin
                        buf_pc[0]   <= pc;
                        buf_inst[0] <= i_imem_inst;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Self-checking bench for rv32i_fetch_ctrl: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expected PCs and flags.
module tb_rv32i_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_inst;
    logic        o_if_valid;
    logic [31:0] o_if_inst;
    logic [31:0] o_if_pc;
    logic        i_id_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_halted;
    logic        o_fault;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of fetched words, PC and mode (0 run, 1 halt, 2 fault)
    entry_t      q[$];
    logic [31:0] mpc  = 32'h0;
    int          mode = 0;
    logic        m_pop;
    logic        m_fetch;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    assign i_imem_inst = mem_word(o_imem_addr);

    rv32i_fetch_ctrl #(
        .WIDTH   (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .o_imem_addr  (o_imem_addr),
        .i_imem_inst  (i_imem_inst),
        .o_if_valid   (o_if_valid),
        .o_if_inst    (o_if_inst),
        .o_if_pc      (o_if_pc),
        .i_id_ready   (i_id_ready),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_halt       (i_halt),
        .o_halted     (o_halted),
        .o_fault      (o_fault)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            mpc  = 32'h0;
            mode = 0;
        end else if (mode != 2 && i_redirect) begin
            q.delete();
            mpc  = i_redirect_pc;
            mode = (i_redirect_pc[1:0] != 2'b00) ? 2 : 0;
        end else begin
            m_pop   = (q.size() > 0) && i_id_ready;
            m_fetch = (mode == 0) && !i_halt && ((q.size() < 2) || m_pop);
            if (m_pop) void'(q.pop_front());
            if (m_fetch) begin
                q.push_back({mpc, mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
            if (mode == 0 && i_halt) mode = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = q.size() > 0;
        ei = ev ? q[0].inst : 32'h0000_0013;
        ep = ev ? q[0].pc : 32'h0;
        check("model_addr", o_imem_addr, mpc);
        check("model_valid", 32'(o_if_valid), 32'(ev));
        check("model_inst", o_if_inst, ei);
        check("model_pc", o_if_pc, ep);
        check("model_halted", 32'(o_halted), 32'((mode == 1) && !ev));
        check("model_fault", 32'(o_fault), 32'(mode == 2));
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        rst           = 1'b0;
        i_id_ready    = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_halt        = 1'b0;

        step();
        check("rst_addr", o_imem_addr, 32'h0);
        check("rst_valid", 32'(o_if_valid), 32'h0);
        check("rst_inst", o_if_inst, 32'h0000_0013);
        check("rst_pc", o_if_pc, 32'h0);
        check("rst_halted", 32'(o_halted), 32'h0);
        check("rst_fault", 32'(o_fault), 32'h0);
        step();
        rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            step();
            check("seq_pc", o_if_pc, 32'(4 * k));
            check("seq_inst", o_if_inst, mem_word(32'(4 * k)));
        end

        i_id_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_head", o_if_pc, 32'd16);
            check("stall_addr", o_imem_addr, 32'd24);
        end
        i_id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("release_pc", o_if_pc, 32'(20 + 4 * k));
        end

        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        step();
        i_redirect = 1'b0;
        check("redir_valid", 32'(o_if_valid), 32'h0);
        check("redir_addr", o_imem_addr, 32'h40);
        step();
        check("redir_head", o_if_pc, 32'h40);
        step();
        check("redir_next", o_if_pc, 32'h44);
        i_id_ready = 1'b0;
        step();
        check("fill_head", o_if_pc, 32'h44);
        check("fill_addr", o_imem_addr, 32'h4C);
        i_id_ready = 1'b1;
        i_halt     = 1'b1;
        step();
        i_halt = 1'b0;
        check("halt_drain_pc", o_if_pc, 32'h48);
        check("halt_drain_halted", 32'(o_halted), 32'h0);
        step();
        check("halted_set", 32'(o_halted), 32'h1);
        check("halted_valid", 32'(o_if_valid), 32'h0);
        check("halted_addr", o_imem_addr, 32'h4C);
        step();
        check("halted_hold", 32'(o_halted), 32'h1);
        check("halted_addr_hold", o_imem_addr, 32'h4C);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h80;
        step();
        i_redirect = 1'b0;
        check("resume_halted", 32'(o_halted), 32'h0);
        check("resume_addr", o_imem_addr, 32'h80);
        step();
        check("resume_head", o_if_pc, 32'h80);

        i_redirect    = 1'b1;
        i_redirect_pc = 32'h42;
        step();
        check("fault_set", 32'(o_fault), 32'h1);
        check("fault_valid", 32'(o_if_valid), 32'h0);
        check("fault_addr", o_imem_addr, 32'h42);
        i_redirect_pc = 32'h0;
        i_halt        = 1'b1;
        step();
        i_redirect = 1'b0;
        i_halt     = 1'b0;
        check("fault_ignore_redir", o_imem_addr, 32'h42);
        check("fault_sticky", 32'(o_fault), 32'h1);
        step();
        step();
        check("fault_still_invalid", 32'(o_if_valid), 32'h0);
        rst = 1'b0;
        step();
        check("fault_cleared", 32'(o_fault), 32'h0);
        check("fault_rst_addr", o_imem_addr, 32'h0);
        rst = 1'b1;
        step();
        check("restart_head", o_if_pc, 32'h0);

        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        step();
        i_redirect = 1'b0;
        check("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_head0", o_if_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_head1", o_if_pc, 32'h0);
        step();
        check("wrap_head2", o_if_pc, 32'h4);

        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(o_if_valid), 32'h0);
        check("async_addr", o_imem_addr, 32'h0);
        check("async_inst", o_if_inst, 32'h0000_0013);
        step();
        rst = 1'b1;
        step();
        step();
        check("post_async_head", o_if_pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
